vga_disp_ctrl: RTL and testbench
================================

# vga_disp_ctrl

Parametrised VGA/LCD display controller that generates sync timing and renders a filled circle over a background colour, with the circle's centre, radius and colours reconfigurable at runtime. It replaces the fixed 640x480 red/green test-pattern driver as the pixel source feeding the LCD/VGA DAC pins. A 3-stage pixel pipeline keeps the area arithmetic off the critical path, and every output is delayed equally so that sync and data stay aligned.

## Interface
Parameters:
- H_SYNC, 96, horizontal sync width in clocks
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (H_TOTAL = sum = 800)
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (V_TOTAL = 525)
- HS_POL, 0, active level of hsync
- VS_POL, 0, active level of vsync
- RGB_W, 16, pixel width (RGB565)
- DEF_CX, 320, reset circle centre x (active coordinates)
- DEF_CY, 240, reset circle centre y
- DEF_R, 50, reset radius
- DEF_FG, 16'h07E0, reset foreground colour
- DEF_BG, 16'hFFFF, reset background colour

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  controller can accept a configuration
- cfg_cx  in  11  centre x
- cfg_cy  in  11  centre y
- cfg_r  in  10  radius
- cfg_fg  in  RGB_W  circle colour
- cfg_bg  in  RGB_W  background colour
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable (visible pixel)
- lcd_rgb  out  RGB_W  pixel data; 0 when de=0
- frame_start  out  1  one-cycle pulse, aligned with the first visible pixel of a frame

## Operation
- h_cnt counts 0..H_TOTAL-1 every clock and wraps. v_cnt increments only when h_cnt == H_TOTAL-1, and wraps after V_TOTAL-1.
- Sync is active while h_cnt < H_SYNC (hsync) or v_cnt < V_SYNC (vsync); otherwise it is at the inactive level.
- Visible when H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE, with the same rule for v_cnt. The pixel coordinates are x = h_cnt-(H_SYNC+H_BACK) and y = v_cnt-(V_SYNC+V_BACK).
- Circle test: dx = x-cx and dy = y-cy, both signed 12-bit. Squares are unsigned 22-bit; the sum is 23-bit; r² is 20-bit. The pixel is inside iff dx²+dy² < r² (strict). Inside gives fg, outside gives bg. Not visible gives 0.
- Configuration handshake:
  - A transfer occurs on cfg_valid && cfg_ready and loads the pending registers.
  - cfg_ready = !pending_full.
  - At the frame boundary (h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1), a full pending register is copied into the active registers and pending_full is cleared.
  - A transfer in the same cycle as the boundary goes to pending and is applied at the next boundary.
  - The active registers never change mid-frame.
- cfg_r = 0 means no circle is drawn; the whole frame shows bg.
- Reset, including mid-frame, clears counters and pipeline and restores the DEF_* values. pending_full=0.

## Timing
- Reset values:
  - hsync = !HS_POL, vsync = !VS_POL
  - de = 0, lcd_rgb = 0, frame_start = 0
  - cfg_ready = 1
  - h_cnt = v_cnt = 0
- Pipeline:
  - S1 registers dx, dy and flags.
  - S2 registers the squares.
  - S3 registers the compare, the colour select and all outputs.
- hsync, vsync, de, lcd_rgb and frame_start all reflect counter state from 3 clocks earlier. There is no skew between them.
- After reset release, the first hsync active level appears at output on clock 3. Line period is H_TOTAL clocks; frame period is H_TOTAL*V_TOTAL clocks (420000 at defaults).
- cfg_ready falls the clock after an accepted transfer. It rises the clock after the frame boundary.

## Structure
- vga_pkg holds:
  - default timing constants for 640x480@60
  - RGB565 colour constants
  - a function for clog2-based counter widths
- Sub-module vga_timing contains the h/v counters and generates raw sync, visible, x, y and frame-boundary flags. vga_disp_ctrl adds the config registers, the 3-stage pipeline and the output alignment.

## Test plan
- Reset held, then released → outputs hold reset values during reset. hsync first active on clock 3 and stays active for 96 clocks, with an 800-clock period. vsync stays active for 1600 clocks per 420000.
- Default config, sample during de → (320,240)=16'h07E0, (0,0)=16'hFFFF, (369,240)=16'h07E0, (370,240)=16'hFFFF (2500 not < 2500), and lcd_rgb=0 whenever de=0.
- Accept cfg cx=100, cy=100, r=10, fg=16'hF800 mid-frame → current frame unchanged. From the next frame, (100,100)=16'hF800 and (320,240)=bg. cfg_ready stays 0 until the boundary.
- Present cfg_valid exactly on the boundary cycle → the value is applied one frame later, not immediately.
- cfg_r=0 → entire visible area is bg. cx=0, cy=0, r=20 → no wrap artefacts: (639,479)=bg and (5,5)=fg.
- Assert rst mid-line → all outputs return to reset values asynchronously. Timing restarts from h_cnt=0, v_cnt=0 and the DEF_* config.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA/LCD display controller.
//   - default 640x480@60 timing constants (pixel clock domain)
//   - RGB565 colour constants
//   - per-pixel sync/enable flag bundle carried down the pixel pipeline
//   - cnt_w(): counter width helper built on $clog2
package vga_pkg;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;

  // Sync flags are polarity-free ("sync region active"); polarity is
  // applied only at the output register.
  typedef struct packed {
    logic hs;   // inside horizontal sync region
    logic vs;   // inside vertical sync region
    logic de;   // visible pixel
    logic fs;   // first visible pixel of the frame
  } pix_flags_t;

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running horizontal/vertical counters and raw timing flags.
// Ports:
//   clk          pixel clock
//   rst          asynchronous, active-low reset (counters to 0)
//   hs_act_o     h_cnt is inside the hsync region
//   vs_act_o     v_cnt is inside the vsync region
//   vis_o        current counter position is a visible pixel
//   first_pix_o  current position is the first visible pixel of the frame
//   frame_end_o  last counter position of the frame (frame boundary)
//   x_o, y_o     active-area pixel coordinates (valid only while vis_o)
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FRONT  = VGA_V_FRONT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        hs_act_o,
  output logic        vs_act_o,
  output logic        vis_o,
  output logic        first_pix_o,
  output logic        frame_end_o,
  output logic [10:0] x_o,
  output logic [10:0] y_o
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  // One spare count so the end-of-visible constant fits even with a zero porch.
  localparam int HW = cnt_w(H_TOTAL + 1);
  localparam int VW = cnt_w(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_E  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_VIS_B   = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_VIS_E   = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_E  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_VIS_B   = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_VIS_E   = VW'(V_SYNC + V_BACK + V_ACTIVE);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign hs_act_o    = (h_cnt_q < H_SYNC_E);
  assign vs_act_o    = (v_cnt_q < V_SYNC_E);
  assign vis_o       = (h_cnt_q >= H_VIS_B) && (h_cnt_q < H_VIS_E) &&
                       (v_cnt_q >= V_VIS_B) && (v_cnt_q < V_VIS_E);
  assign first_pix_o = (h_cnt_q == H_VIS_B) && (v_cnt_q == V_VIS_B);
  assign frame_end_o = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  // Offsets wrap outside the visible window; downstream ignores them there.
  assign x_o         = 11'(h_cnt_q - H_VIS_B);
  assign y_o         = 11'(v_cnt_q - V_VIS_B);

endmodule

// File: rtl/vga_disp_ctrl.sv
// vga_disp_ctrl: VGA/LCD controller drawing a filled circle over a background.
// Ports:
//   clk, rst                 pixel clock, asynchronous active-low reset
//   cfg_valid / cfg_ready    configuration handshake (one pending slot)
//   cfg_cx, cfg_cy, cfg_r    circle centre (active coordinates) and radius
//   cfg_fg, cfg_bg           circle and background colours
//   hsync, vsync, de         display timing outputs
//   lcd_rgb                  pixel data, 0 outside the visible area
//   frame_start              pulse on the first visible pixel of a frame
// Every output leaves the same 3-stage pipeline, so all are skew-free and
// lag the counters by exactly 3 clocks.
module vga_disp_ctrl
  import vga_pkg::*;
#(
  parameter int               H_SYNC   = VGA_H_SYNC,
  parameter int               H_BACK   = VGA_H_BACK,
  parameter int               H_ACTIVE = VGA_H_ACTIVE,
  parameter int               H_FRONT  = VGA_H_FRONT,
  parameter int               V_SYNC   = VGA_V_SYNC,
  parameter int               V_BACK   = VGA_V_BACK,
  parameter int               V_ACTIVE = VGA_V_ACTIVE,
  parameter int               V_FRONT  = VGA_V_FRONT,
  parameter bit               HS_POL   = 1'b0,
  parameter bit               VS_POL   = 1'b0,
  parameter int               RGB_W    = 16,
  parameter logic [10:0]      DEF_CX   = 11'd320,
  parameter logic [10:0]      DEF_CY   = 11'd240,
  parameter logic [9:0]       DEF_R    = 10'd50,
  parameter logic [RGB_W-1:0] DEF_FG   = RGB_W'(RGB565_GREEN),
  parameter logic [RGB_W-1:0] DEF_BG   = RGB_W'(RGB565_WHITE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [10:0]      cfg_cx,
  input  logic [10:0]      cfg_cy,
  input  logic [9:0]       cfg_r,
  input  logic [RGB_W-1:0] cfg_fg,
  input  logic [RGB_W-1:0] cfg_bg,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] lcd_rgb,
  output logic             frame_start
);

  // ---------------------------------------------------------------- timing
  logic        raw_hs, raw_vs, raw_vis, raw_first, raw_end;
  logic [10:0] raw_x, raw_y;

  vga_timing #(
    .H_SYNC  (H_SYNC),   .H_BACK  (H_BACK),
    .H_ACTIVE(H_ACTIVE), .H_FRONT (H_FRONT),
    .V_SYNC  (V_SYNC),   .V_BACK  (V_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT (V_FRONT)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .hs_act_o   (raw_hs),
    .vs_act_o   (raw_vs),
    .vis_o      (raw_vis),
    .first_pix_o(raw_first),
    .frame_end_o(raw_end),
    .x_o        (raw_x),
    .y_o        (raw_y)
  );

  // --------------------------------------------------------- configuration
  logic [10:0]      cx_q, cy_q, pcx_q, pcy_q;
  logic [9:0]       r_q, pr_q;
  logic [RGB_W-1:0] fg_q, bg_q, pfg_q, pbg_q;
  logic             pend_q;

  assign cfg_ready = !pend_q;

  // Active registers only change on the frame boundary. A transfer on the
  // boundary itself can only happen when the slot was empty, so it simply
  // fills the slot and waits for the following boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx_q   <= DEF_CX;
      cy_q   <= DEF_CY;
      r_q    <= DEF_R;
      fg_q   <= DEF_FG;
      bg_q   <= DEF_BG;
      pcx_q  <= '0;
      pcy_q  <= '0;
      pr_q   <= '0;
      pfg_q  <= '0;
      pbg_q  <= '0;
      pend_q <= 1'b0;
    end else if (raw_end && pend_q) begin
      cx_q   <= pcx_q;
      cy_q   <= pcy_q;
      r_q    <= pr_q;
      fg_q   <= pfg_q;
      bg_q   <= pbg_q;
      pend_q <= 1'b0;
    end else if (cfg_valid && !pend_q) begin
      pcx_q  <= cfg_cx;
      pcy_q  <= cfg_cy;
      pr_q   <= cfg_r;
      pfg_q  <= cfg_fg;
      pbg_q  <= cfg_bg;
      pend_q <= 1'b1;
    end
  end

  // -------------------------------------------------------------- pipeline
  // Radius and colours travel with each pixel so a config swap can never
  // pair a pixel with another frame's parameters.
  pix_flags_t       flags_d, s1_flags_q, s2_flags_q;
  logic [11:0]      dx_d, dy_d, s1_dx_q, s1_dy_q;
  logic [19:0]      rsq_d, s1_rsq_q, s2_rsq_q;
  logic [RGB_W-1:0] s1_fg_q, s1_bg_q, s2_fg_q, s2_bg_q;
  logic [10:0]      adx, ady;
  logic [21:0]      dx2_d, dy2_d, s2_dx2_q, s2_dy2_q;
  logic [22:0]      dist_d;
  logic             inside_d;

  assign flags_d = '{hs: raw_hs, vs: raw_vs, de: raw_vis, fs: raw_first};
  // Zero-extended operands make the 12-bit difference a correct signed value.
  assign dx_d    = {1'b0, raw_x} - {1'b0, cx_q};
  assign dy_d    = {1'b0, raw_y} - {1'b0, cy_q};
  assign rsq_d   = {10'd0, r_q} * {10'd0, r_q};

  // |d| never exceeds 2047, so squaring the magnitude fits in 22 bits.
  assign adx     = s1_dx_q[11] ? 11'(12'd0 - s1_dx_q) : s1_dx_q[10:0];
  assign ady     = s1_dy_q[11] ? 11'(12'd0 - s1_dy_q) : s1_dy_q[10:0];
  assign dx2_d   = {11'd0, adx} * {11'd0, adx};
  assign dy2_d   = {11'd0, ady} * {11'd0, ady};

  assign dist_d   = {1'b0, s2_dx2_q} + {1'b0, s2_dy2_q};
  assign inside_d = (dist_d < {3'd0, s2_rsq_q});   // strict: r = 0 draws nothing

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_flags_q <= '0;
      s1_dx_q    <= '0;
      s1_dy_q    <= '0;
      s1_rsq_q   <= '0;
      s1_fg_q    <= '0;
      s1_bg_q    <= '0;
      s2_flags_q <= '0;
      s2_dx2_q   <= '0;
      s2_dy2_q   <= '0;
      s2_rsq_q   <= '0;
      s2_fg_q    <= '0;
      s2_bg_q    <= '0;
    end else begin
      s1_flags_q <= flags_d;
      s1_dx_q    <= dx_d;
      s1_dy_q    <= dy_d;
      s1_rsq_q   <= rsq_d;
      s1_fg_q    <= fg_q;
      s1_bg_q    <= bg_q;
      s2_flags_q <= s1_flags_q;
      s2_dx2_q   <= dx2_d;
      s2_dy2_q   <= dy2_d;
      s2_rsq_q   <= s1_rsq_q;
      s2_fg_q    <= s1_fg_q;
      s2_bg_q    <= s1_bg_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync       <= !HS_POL;
      vsync       <= !VS_POL;
      de          <= 1'b0;
      lcd_rgb     <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= s2_flags_q.hs ? HS_POL : !HS_POL;
      vsync       <= s2_flags_q.vs ? VS_POL : !VS_POL;
      de          <= s2_flags_q.de;
      lcd_rgb     <= !s2_flags_q.de ? '0 : (inside_d ? s2_fg_q : s2_bg_q);
      frame_start <= s2_flags_q.fs;
    end
  end

endmodule

// File: tb/tb_vga_disp_ctrl.sv
module tb_vga_disp_ctrl;
  import vga_pkg::*;

  // Reduced timing so many frames fit in a short run.
  localparam int HS = 4, HB = 3, HA = 40, HF = 5;
  localparam int VS = 2, VB = 3, VA = 30, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int F  = HT * VT;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b1;
  localparam int DCX = 20, DCY = 15, DR = 6;
  localparam int DFG = 16'h07E0, DBG = 16'hFFFF;

  typedef struct { int cx; int cy; int r; int fg; int bg; } cfg_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [10:0] cfg_cx = '0, cfg_cy = '0;
  logic [9:0]  cfg_r = '0;
  logic [15:0] cfg_fg = '0, cfg_bg = '0;
  logic        hsync, vsync, de, frame_start;
  logic [15:0] lcd_rgb;

  always #5 clk = ~clk;

  vga_disp_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .RGB_W(16),
    .DEF_CX(11'(DCX)), .DEF_CY(11'(DCY)), .DEF_R(10'(DR)),
    .DEF_FG(16'(DFG)), .DEF_BG(16'(DBG))
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_cx(cfg_cx), .cfg_cy(cfg_cy), .cfg_r(cfg_r),
    .cfg_fg(cfg_fg), .cfg_bg(cfg_bg),
    .hsync(hsync), .vsync(vsync), .de(de),
    .lcd_rgb(lcd_rgb), .frame_start(frame_start)
  );

  // ------------------------------------------------------ model state
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_edges  = 0;      // clock edges since reset release = counter value
  bit   in_reset = 1'b1;
  int   exp_q[$];          // expected visible pixels, in raster order
  cfg_t cur_cfg, pend_cfg;
  int   pend_frame = -1;   // frame index the pending config first applies to
  int   pend_lo = 1, pend_hi = 0;  // counter range in which cfg_ready must be 0

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, n_edges);
  endfunction

  // Whole-frame reference image from the geometric rule.
  function automatic void push_frame(input int f);
    int dx, dy;
    if (pend_frame == f) begin
      cur_cfg    = pend_cfg;
      pend_frame = -1;
    end
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        dx = x - cur_cfg.cx;
        dy = y - cur_cfg.cy;
        exp_q.push_back((dx * dx + dy * dy < cur_cfg.r * cur_cfg.r) ? cur_cfg.fg : cur_cfg.bg);
      end
    end
  endfunction

  always @(posedge clk) begin
    if (!in_reset) begin
      n_edges++;
      if (n_edges % F == 0) push_frame(n_edges / F);
    end
  end

  // ------------------------------------------------------ monitor
  int m_t, m_h, m_v;
  bit e_hs, e_vs, e_de, e_fs, e_rdy;

  always @(negedge clk) begin
    if (in_reset) begin
      chk("rst_state", {27'd0, hsync, vsync, de, frame_start, cfg_ready},
          {27'd0, !HS_POL, !VS_POL, 1'b0, 1'b0, 1'b1});
      chk("rst_rgb", {16'd0, lcd_rgb}, 32'd0);
    end else begin
      if (n_edges < 3) begin
        e_hs = !HS_POL; e_vs = !VS_POL; e_de = 1'b0; e_fs = 1'b0;
      end else begin
        m_t  = n_edges - 3;
        m_h  = m_t % HT;
        m_v  = (m_t / HT) % VT;
        e_hs = (m_h < HS) ? HS_POL : !HS_POL;
        e_vs = (m_v < VS) ? VS_POL : !VS_POL;
        e_de = (m_h >= HS + HB) && (m_h < HS + HB + HA) && (m_v >= VS + VB) && (m_v < VS + VB + VA);
        e_fs = (m_h == HS + HB) && (m_v == VS + VB);
      end
      chk("sync_de_fs", {28'd0, hsync, vsync, de, frame_start}, {28'd0, e_hs, e_vs, e_de, e_fs});
      e_rdy = !(n_edges >= pend_lo && n_edges <= pend_hi);
      chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, e_rdy});
      if (de === 1'b1) begin
        if (exp_q.size() == 0) chk("pix_underflow", 32'd1, 32'd0);
        else chk("pix", {16'd0, lcd_rgb}, exp_q.pop_front());
      end else begin
        chk("blank_rgb", {16'd0, lcd_rgb}, 32'd0);
      end
    end
  end

  // ------------------------------------------------------ stimulus
  task automatic release_reset();
    @(negedge clk);
    #1;
    exp_q.delete();
    cur_cfg    = '{DCX, DCY, DR, DFG, DBG};
    pend_frame = -1;
    pend_lo    = 1;
    pend_hi    = 0;
    n_edges    = 0;
    push_frame(0);
    rst      = 1'b1;
    in_reset = 1'b0;
    $display("reset released");
  endtask

  // Offer c at counter value 'at' (or as soon as ready when at < 0).
  task automatic send_cfg(input cfg_t c, input int at);
    int guard, t;
    guard = 0;
    @(negedge clk);
    while (at >= 0 && n_edges < at) @(negedge clk);
    while (cfg_ready !== 1'b1 && guard < 4 * F) begin
      @(negedge clk);
      guard++;
    end
    if (cfg_ready !== 1'b1) begin
      chk("cfg_ready_timeout", {31'd0, cfg_ready}, 32'd1);
      return;
    end
    t = n_edges;
    cfg_cx = 11'(c.cx);
    cfg_cy = 11'(c.cy);
    cfg_r  = 10'(c.r);
    cfg_fg = 16'(c.fg);
    cfg_bg = 16'(c.bg);
    cfg_valid  = 1'b1;
    pend_cfg   = c;
    pend_frame = (t + 1) / F + 1;
    pend_lo    = t + 1;
    pend_hi    = pend_frame * F - 1;
    $display("cfg t=%0d h=%0d v=%0d cx=%0d cy=%0d r=%0d fg=%0h bg=%0h -> frame %0d",
             t, t % HT, (t / HT) % VT, c.cx, c.cy, c.r, c.fg, c.bg, pend_frame);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.cx = int'($urandom_range(0, HA + 8));
    c.cy = int'($urandom_range(0, VA + 8));
    c.r  = int'($urandom_range(0, 20));
    c.fg = int'($urandom_range(0, 65535));
    c.bg = int'($urandom_range(0, 65535));
    if ($urandom_range(0, 4) == 0) c.cx = int'($urandom_range(0, 2047));
    return c;
  endfunction

  initial begin
    cfg_t c;
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    release_reset();

    // Mid-frame change: frame 0 keeps defaults, frame 1 uses the new circle.
    c = '{8, 8, 5, int'(RGB565_RED), int'(RGB565_BLUE)};
    send_cfg(c, 500);
    // Offered exactly on the boundary cycle: takes effect one frame later.
    c = '{20, 15, 0, int'(RGB565_RED), int'(RGB565_GREEN)};
    send_cfg(c, 2 * F - 1);
    // Circle in the corner; must not wrap to the far edges.
    c = '{0, 0, 6, int'(RGB565_RED), int'(RGB565_WHITE)};
    send_cfg(c, -1);

    repeat (6) begin
      c = rand_cfg();
      send_cfg(c, n_edges + int'($urandom_range(1, F)));
    end
    c = rand_cfg();
    send_cfg(c, ((n_edges / F) + 2) * F - 1);

    // Asynchronous reset in the middle of a line with a config pending.
    c = rand_cfg();
    send_cfg(c, -1);
    repeat (300) @(negedge clk);
    while (n_edges % HT != 25) @(negedge clk);
    #2;
    in_reset = 1'b1;
    rst      = 1'b0;
    #1;
    chk("async_rst", {27'd0, hsync, vsync, de, frame_start, cfg_ready},
        {27'd0, !HS_POL, !VS_POL, 1'b0, 1'b0, 1'b1});
    chk("async_rst_rgb", {16'd0, lcd_rgb}, 32'd0);
    repeat (3) @(negedge clk);
    release_reset();
    repeat (F + F / 2 + 100) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
